// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller with drain-to-halt sequencing.
// Optional stall performance counter is built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_r,
    input  logic        ex_wb_en,
    input  logic        ex_terminate,
    input  logic [4:0]  ex_reg_dest,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_hold,
    output logic        id_ex_bubble,
    output logic        halt,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_halt;
    logic       w_hazard;

    // Load-use: the EX instruction is a load whose result the ID instruction needs.
    assign w_hazard = ex_mem_r & ex_wb_en & (ex_reg_dest != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_reg_dest)) |
                       (id_uses_rt & (id_rt == ex_reg_dest)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst) begin
            case (r_state)
                S_RUN: begin
                    if (mem_busy) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_hold  = 1'b1;
                    end else if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (w_hazard) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                S_DRAIN: begin
                    pc_stall     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    id_ex_hold   = mem_busy;
                end
                S_HALTED: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (ex_terminate && !mem_busy) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= LP_CNT_INIT;
                    end
                end
                S_DRAIN: begin
                    // A memory wait freezes the drain so in-flight work is not lost.
                    if (!mem_busy) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= S_HALTED;
                            r_halt  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                S_HALTED: r_halt <= 1'b1;
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= 4'd0;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    assign halt = r_halt;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == S_RUN) && pc_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
